// File: rtl/program_loader_pkg.sv
// Shared definitions for the program memory loader: FSM encoding,
// bytes-per-word helper and the word-aligned address step.
package program_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RECV  = ST_RECV,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } loader_state_t;

    // Byte address step between consecutive instruction words.
    localparam int ADDR_INCREMENT = 4;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Shifts bytes into an instruction word, most significant byte first,
// and flags when a full word has been collected.
module byte_word_packer
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_full,
    output logic                  last_byte
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int CW  = $clog2(BPW + 1);

    logic [DATA_WIDTH-1:0] word_reg;
    logic [CW-1:0]         count_reg;
    logic                  full_reg;

    // Each byte lane takes the lane below it; lane 0 takes the new byte.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign word_next[7:0] = byte_in;
            end else begin : g_shift
                assign word_next[8*gi +: 8] = word_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign last_byte = (count_reg == CW'(BPW - 1));
    assign word_full = full_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            word_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (shift_en && !full_reg) begin
            word_reg  <= word_next;
            count_reg <= count_reg + 1'b1;
            full_reg  <= last_byte;
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a byte-streamed program into instruction memory, holding the CPU
// in reset for the duration and reporting completion or a bad word count.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] word_count_i,
    input  logic [7:0]             byte_i,
    input  logic                   byte_valid_i,
    output logic                   byte_ready_o,
    output logic                   mem_we_o,
    output logic [DATA_WIDTH-1:0]  mem_address_o,
    output logic [DATA_WIDTH-1:0]  mem_data_o,
    output logic                   busy_o,
    output logic                   cpu_hold_o,
    output logic                   done_o,
    output logic                   error_o
);

    localparam logic [COUNT_WIDTH:0] DEPTH_LIMIT = (COUNT_WIDTH + 1)'(MEMORY_DEPTH);

    loader_state_t          state_reg, state_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [COUNT_WIDTH-1:0] words_reg, words_next;
    logic [DATA_WIDTH-1:0]  addr_reg, addr_next;
    logic                   ready_reg, ready_next;
    logic                   we_reg, we_next;
    logic [DATA_WIDTH-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]  mem_data_reg, mem_data_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   error_reg, error_next;

    logic                   xfer;
    logic                   packer_clear;
    logic [DATA_WIDTH-1:0]  packed_word;
    logic                   word_full;
    logic                   last_byte;
    logic [COUNT_WIDTH-1:0] words_inc;

    assign xfer      = byte_valid_i && ready_reg;
    assign words_inc = words_reg + 1'b1;

    byte_word_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .srst      (reset),
        .clear     (packer_clear),
        .shift_en  (xfer),
        .byte_in   (byte_i),
        .word_next (packed_word),
        .word_full (word_full),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            words_reg    <= '0;
            addr_reg     <= '0;
            ready_reg    <= 1'b0;
            we_reg       <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            words_reg    <= words_next;
            addr_reg     <= addr_next;
            ready_reg    <= ready_next;
            we_reg       <= we_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        words_next    = words_reg;
        addr_next     = addr_reg;
        ready_next    = ready_reg;
        we_next       = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        error_next    = error_reg;
        packer_clear  = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b0;
                busy_next  = 1'b0;
                if (start_i) begin
                    if (word_count_i == '0) begin
                        error_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else if ({1'b0, word_count_i} > DEPTH_LIMIT) begin
                        error_next = 1'b1;
                    end else begin
                        count_next = word_count_i;
                        words_next = '0;
                        addr_next  = BASE_ADDRESS;
                        error_next = 1'b0;
                        busy_next  = 1'b1;
                        ready_next = 1'b1;
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                // The write strobe and its payload are registered on the same
                // edge that accepts the final byte of the word.
                if (xfer && last_byte && !word_full) begin
                    ready_next    = 1'b0;
                    we_next       = 1'b1;
                    mem_addr_next = addr_reg;
                    mem_data_next = packed_word;
                    state_next    = WRITE;
                end
            end
            WRITE: begin
                packer_clear = 1'b1;
                addr_next    = addr_reg + DATA_WIDTH'(ADDR_INCREMENT);
                words_next   = words_inc;
                if (words_inc == count_reg) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    ready_next = 1'b1;
                    state_next = RECV;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                ready_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_ready_o  = ready_reg;
    assign mem_we_o      = we_reg;
    assign mem_address_o = mem_addr_reg;
    assign mem_data_o    = mem_data_reg;
    assign busy_o        = busy_reg;
    assign cpu_hold_o    = busy_reg;
    assign done_o        = done_reg;
    assign error_o       = error_reg;

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Write-side counterpart of the instruction ROM. Receives a program as a byte stream over a valid/ready handshake and packs each group of bytes into an instruction word, most significant byte first.
- Drives the write port of the instruction memory with word-aligned byte addresses.
- Holds the CPU in reset while loading and reports done or error.
- Sits between the host/UART byte source and the program memory, ahead of the single-cycle datapath.

Parameters:
MEMORY_DEPTH, 32, number of instruction words in program memory
DATA_WIDTH, 32, instruction/address width; must be a multiple of 8
BASE_ADDRESS, 0, byte address of the first word written
COUNT_WIDTH, 16, width of word_count_i

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start_i  input  1  single-cycle pulse; begins a load
word_count_i  input  COUNT_WIDTH  words to load; sampled on start_i
byte_i  input  8  program byte
byte_valid_i  input  1  byte_i valid
byte_ready_o  output  1  loader accepts a byte this cycle
mem_we_o  output  1  write strobe to program memory
mem_address_o  output  DATA_WIDTH  byte address, word aligned
mem_data_o  output  DATA_WIDTH  assembled instruction word
busy_o  output  1  load in progress
cpu_hold_o  output  1  keep CPU in reset; equals busy_o
done_o  output  1  one-cycle pulse at load completion
error_o  output  1  sticky: rejected word count

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Internal state returns to IDLE, and the byte counter, word counter and assembly register clear.
- BPW = DATA_WIDTH/8.
- A byte transfer occurs when byte_valid_i and byte_ready_o are both high on a rising edge.

IDLE:
- byte_ready_o=0, busy_o=0.
- On start_i with word_count_i==0: go to DONE with no writes and no error.
- On start_i with word_count_i>MEMORY_DEPTH: set error_o and stay in IDLE.
- Otherwise: latch the count, set address=BASE_ADDRESS, clear error_o, set busy_o, go to RECV.

RECV:
- byte_ready_o=1.
- Each transfer shifts the byte in: word={word[DATA_WIDTH-9:0],byte_i}, and the byte counter increments.
- On the BPW-th transfer: byte_ready_o drops on the next cycle, go to WRITE.
- byte_valid_i low: state is held indefinitely; there is no timeout.

WRITE:
- Exactly one cycle with mem_we_o=1, mem_address_o=current address, mem_data_o=assembled word.
- Then address+=4 (wraps modulo 2^DATA_WIDTH) and words_written++.
- If words_written==count, go to DONE; else go to RECV.

DONE:
- done_o=1 for exactly one cycle; busy_o and cpu_hold_o fall on the following cycle; return to IDLE.

Timing:
- Last byte of a word accepted at edge N → mem_we_o high in cycle N+1 → byte_ready_o high again in cycle N+2.
- Throughput: BPW bytes per BPW+1 cycles.

Edge cases:
- start_i while busy is ignored, and word_count_i is not resampled.
- mem_address_o and mem_data_o hold their last values when mem_we_o=0.
- Reset mid-load: the partial word is discarded, no write is issued, cpu_hold_o falls the cycle after reset, and words already written remain in memory.
- error_o clears only on reset or on a later accepted start.

Decomposition:
- Shared package program_loader_pkg holds:
  - the state encoding IDLE/RECV/WRITE/DONE as 2-bit localparams;
  - BPW derived from DATA_WIDTH;
  - the address increment constant 4.
- One sub-module, byte_word_packer: shift register, byte counter, and a word_full flag with a clear input. The FSM, address counter and word counter stay in the top level.

Test Plan:
1. Reset, start_i with count=2, bytes 8'h20,08,00,05,8'h21,29,FF,FF back-to-back → writes 32'h20080005 @0x0 and 32'h2129FFFF @0x4. done_o pulses 1 cycle after the second write. cpu_hold_o is high throughout and low afterwards.
2. Same load with byte_valid_i low for 3 cycles between bytes 2 and 3 → identical writes, no extra mem_we_o, busy_o held.
3. start_i with count=33 (MEMORY_DEPTH=32) → error_o=1, no writes, byte_ready_o stays 0. A subsequent start_i with count=1 clears error_o.
4. start_i with count=0 → done_o pulse, no mem_we_o, error_o=0.
5. Assert reset after 2 bytes of word 1 (count=3) → no write occurs, all outputs 0 next cycle. A fresh load of count=1 then writes @BASE_ADDRESS with the new bytes only.
6. Load count=32 → 32 writes at addresses 0x00..0x7C, each mem_we_o exactly one cycle; a start_i pulse mid-load has no effect.
